// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle path: screen-sized position defaults,
// quadrature gray-code state names, direction encoding and the edge decoder.
// Pure declarations; no logic, no latency, no backpressure.
package pong_pkg;

  // Defaults sized for a 640x480 screen: vertical paddle travel 0..479.
  localparam int PONG_POS_WIDTH = 10;
  localparam int PONG_POS_MIN   = 0;
  localparam int PONG_POS_MAX   = 479;

  // The four quadrature states, written as {A,B}.
  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_10 = 2'b10;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_01 = 2'b01;

  // Direction encoding: up means A leads B.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Result of comparing two consecutive filtered {A,B} samples.
  typedef struct packed {
    logic up;
    logic down;
    logic illegal;
  } quad_step_t;

  // Up walks 00->10->11->01->00, down walks the reverse. A change of both
  // bits at once cannot be attributed to a direction and is flagged illegal.
  function automatic quad_step_t quad_decode(input logic [1:0] prev,
                                             input logic [1:0] cur);
    quad_step_t s;
    s = '0;
    case ({prev, cur})
      {GRAY_00, GRAY_10},
      {GRAY_10, GRAY_11},
      {GRAY_11, GRAY_01},
      {GRAY_01, GRAY_00}: s.up = 1'b1;
      {GRAY_00, GRAY_01},
      {GRAY_01, GRAY_11},
      {GRAY_11, GRAY_10},
      {GRAY_10, GRAY_00}: s.down = 1'b1;
      default:            s.illegal = ((prev ^ cur) == 2'b11);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Purpose: bring one asynchronous encoder pin into clk and reject short glitches.
// Latency: pin change reaches out after 2 (synchronizer) + FILTER_LEN cycles.
// Backpressure: none; free-running sampler.
// Ports: clk, reset (async, active-high), in (async pin), out (filtered bit).
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= in;
      sync_q    <= sync_meta;
    end
  end

  // cnt counts consecutive cycles where the synced value disagrees with out.
  // The FILTER_LEN-th disagreeing cycle commits the new value; any agreeing
  // cycle restarts the count, so a short glitch never reaches out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (sync_q == out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      out <= sync_q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_paddle_decoder.sv
// Purpose: quadrature encoder -> saturating paddle position, plus a copy
//          latched on each vga_v_sync rising edge for the renderer.
// Latency: pin change -> filtered bit 2+FILTER_LEN cycles, pos_live +1, moved +1.
// Backpressure: none; every legal edge is consumed as it arrives.
// Ports: clk, reset (async, active-high), quadA/quadB (async pins),
//        vga_v_sync (frame strobe), pos_live, pos_frame, moved, dir.
// Build option QUAD_ERROR_EN adds err_count[7:0] (saturating illegal-edge
// count) and err_flag (sticky). Without it illegal edges are dropped silently.
module quad_paddle_decoder
  import pong_pkg::*;
#(
  parameter int POS_WIDTH  = PONG_POS_WIDTH,
  parameter int POS_MIN    = PONG_POS_MIN,
  parameter int POS_MAX    = PONG_POS_MAX,
  parameter int POS_RESET  = 240,
  parameter int STEP       = 1,
  parameter int FILTER_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 quadA,
  input  logic                 quadB,
  input  logic                 vga_v_sync,
  output logic [POS_WIDTH-1:0] pos_live,
  output logic [POS_WIDTH-1:0] pos_frame,
  output logic                 moved,
  output logic                 dir
`ifdef QUAD_ERROR_EN
  ,
  output logic [7:0]           err_count,
  output logic                 err_flag
`endif
);

  // Parameter sanity, caught at elaboration.
  if (!((POS_MIN <= POS_RESET) && (POS_RESET <= POS_MAX) &&
        (POS_MAX < (1 << POS_WIDTH)))) begin : g_bad_range
    $error("quad_paddle_decoder: need POS_MIN <= POS_RESET <= POS_MAX < 2**POS_WIDTH");
  end
  if (STEP < 1) begin : g_bad_step
    $error("quad_paddle_decoder: STEP must be >= 1");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("quad_paddle_decoder: FILTER_LEN must be >= 1");
  end

  // Clamp arithmetic is done one bit wider than the position so that
  // pos+STEP can exceed the top of the range without wrapping.
  localparam logic [POS_WIDTH:0]   MAX_X     = (POS_WIDTH + 1)'(POS_MAX);
  localparam logic [POS_WIDTH:0]   MIN_X     = (POS_WIDTH + 1)'(POS_MIN);
  localparam logic [POS_WIDTH:0]   STEP_X    = (POS_WIDTH + 1)'(STEP);
  localparam logic [POS_WIDTH-1:0] RESET_POS = POS_WIDTH'(POS_RESET);

  // ---------------------------------------------------------------- inputs
  logic qa_filt;
  logic qb_filt;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .in    (quadA),
    .out   (qa_filt)
  );

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .in    (quadB),
    .out   (qb_filt)
  );

  // ---------------------------------------------------------------- decode
  logic [1:0] ab_cur;
  logic [1:0] ab_prev;
  quad_step_t stp;

  assign ab_cur = {qa_filt, qb_filt};
  assign stp    = quad_decode(ab_prev, ab_cur);

  // ab_prev resets to 00, so an encoder resting at 11 shows up as a
  // double-bit change after reset and is discarded as illegal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_prev <= GRAY_00;
    end else begin
      ab_prev <= ab_cur;
    end
  end

  // -------------------------------------------------------------- position
  logic [POS_WIDTH:0]   pos_x;
  logic [POS_WIDTH:0]   up_sum;
  logic [POS_WIDTH-1:0] pos_next;

  always_comb begin
    pos_x    = {1'b0, pos_live};
    up_sum   = pos_x + STEP_X;
    pos_next = pos_live;
    if (stp.up) begin
      pos_next = (up_sum > MAX_X) ? MAX_X[POS_WIDTH-1:0] : up_sum[POS_WIDTH-1:0];
    end else if (stp.down) begin
      // Compare before subtracting so the floor never wraps below zero.
      pos_next = (pos_x < (MIN_X + STEP_X)) ? MIN_X[POS_WIDTH-1:0]
                                            : (pos_live - STEP_X[POS_WIDTH-1:0]);
    end
  end

  // pos_chg marks the cycle pos_live takes a new value; moved follows it by
  // one cycle. Saturated edges leave pos_next == pos_live and so never pulse.
  logic pos_chg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_live <= RESET_POS;
      pos_chg  <= 1'b0;
      moved    <= 1'b0;
      dir      <= DIR_DOWN;
    end else begin
      pos_live <= pos_next;
      pos_chg  <= (pos_next != pos_live);
      moved    <= pos_chg;
      if (stp.up) begin
        dir <= DIR_UP;
      end else if (stp.down) begin
        dir <= DIR_DOWN;
      end
    end
  end

  // ----------------------------------------------------------- frame latch
  logic vs_meta;
  logic vs_sync;
  logic vs_hist;
  logic vs_rise;

  assign vs_rise = vs_sync & ~vs_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_hist <= 1'b0;
    end else begin
      vs_meta <= vga_v_sync;
      vs_sync <= vs_meta;
      vs_hist <= vs_sync;
    end
  end

  // Latches the registered pos_live, i.e. the value before any update
  // landing on this same edge, so the whole frame sees one position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_frame <= RESET_POS;
    end else if (vs_rise) begin
      pos_frame <= pos_live;
    end
  end

  // ------------------------------------------------------ illegal tracking
`ifdef QUAD_ERROR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
      err_flag  <= 1'b0;
    end else if (stp.illegal) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = stp.illegal;
`endif

endmodule
